instr_fetch: RTL

Instruction fetch unit sitting between the program counter and the decode stage. Issues sequential word-aligned read requests to instruction memory over a valid/ready port, tracks outstanding requests with credits, buffers in-order responses in a small FIFO and hands instruction/PC pairs to decode. Handles redirects (branch/jump/trap) by reloading the fetch PC, flushing buffered instructions and discarding responses to stale in-flight requests.

---
 rtl/instr_fetch.sv | 100 ++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited sequential fetch, in-order response FIFO, redirect flush.
// Optional macro IFETCH_BYPASS_EN: zero-latency response-to-decode path when the FIFO is empty.
module instr_fetch #(
    parameter int DATA_WIDTH_P   = 32,
    parameter int ADDR_WIDTH_P   = 32,
    parameter logic [ADDR_WIDTH_P-1:0] RESET_VECTOR_P = '0,
    parameter int DEPTH_P        = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    o_imem_req_valid,
    input  logic                    i_imem_req_ready,
    output logic [ADDR_WIDTH_P-1:0] o_imem_req_addr,
    input  logic                    i_imem_rsp_valid,
    input  logic [DATA_WIDTH_P-1:0] i_imem_rsp_data,
    input  logic                    i_redirect_valid,
    input  logic [ADDR_WIDTH_P-1:0] i_redirect_pc,
    output logic                    o_instr_valid,
    input  logic                    i_instr_ready,
    output logic [DATA_WIDTH_P-1:0] o_instr,
    output logic [ADDR_WIDTH_P-1:0] o_instr_pc
);
    localparam int CNT_W = $clog2(DEPTH_P + 1);
    localparam int PTR_W = $clog2(DEPTH_P);

    logic [ADDR_WIDTH_P-1:0] r_fetch_pc, r_rsp_pc;
    logic [CNT_W-1:0]        r_outstanding, r_drop_cnt, r_count;
    logic [PTR_W-1:0]        r_rd_ptr, r_wr_ptr;
    logic [DATA_WIDTH_P-1:0] r_mem_instr [DEPTH_P];
    logic [ADDR_WIDTH_P-1:0] r_mem_pc    [DEPTH_P];

    logic                    w_credit_ok, w_req_fire, w_fifo_valid;
    logic                    w_rsp_keep, w_push, w_pop, w_byp_take;
    logic [CNT_W-1:0]        w_out_next;
    logic [ADDR_WIDTH_P-1:0] w_redir_pc;

    // Outstanding requests plus buffered entries never exceed FIFO depth, so pushes cannot overflow.
    assign w_credit_ok  = ({1'b0, r_outstanding} + {1'b0, r_count}) < (CNT_W+1)'(DEPTH_P);
    assign o_imem_req_valid = !reset && !i_redirect_valid && w_credit_ok;
    assign o_imem_req_addr  = r_fetch_pc;
    assign w_req_fire   = o_imem_req_valid && i_imem_req_ready;
    assign w_fifo_valid = (r_count != '0);
    assign w_out_next   = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(i_imem_rsp_valid);
    assign w_redir_pc   = {i_redirect_pc[ADDR_WIDTH_P-1:2], 2'b00};
    assign w_rsp_keep   = i_imem_rsp_valid && (r_drop_cnt == '0) && !i_redirect_valid;
    assign w_pop        = w_fifo_valid && i_instr_ready;

`ifdef IFETCH_BYPASS_EN
    logic w_byp;
    assign w_byp      = !reset && !w_fifo_valid && w_rsp_keep;
    assign w_byp_take = w_byp && i_instr_ready;
    assign o_instr_valid = w_fifo_valid || w_byp;
    assign o_instr    = w_fifo_valid ? r_mem_instr[r_rd_ptr] : (w_byp ? i_imem_rsp_data : '0);
    assign o_instr_pc = w_fifo_valid ? r_mem_pc[r_rd_ptr]    : (w_byp ? r_rsp_pc        : '0);
`else
    assign w_byp_take = 1'b0;
    assign o_instr_valid = w_fifo_valid;
    assign o_instr    = w_fifo_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_instr_pc = w_fifo_valid ? r_mem_pc[r_rd_ptr]    : '0;
`endif

    assign w_push = w_rsp_keep && !w_byp_take;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc    <= RESET_VECTOR_P;
            r_rsp_pc      <= RESET_VECTOR_P;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (i_redirect_valid) begin
                // Everything still in flight after this cycle belongs to the old path.
                r_fetch_pc <= w_redir_pc;
                r_rsp_pc   <= w_redir_pc;
                r_drop_cnt <= w_out_next;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_WIDTH_P'(4);
                if (i_imem_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - 1'b1;
                if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + ADDR_WIDTH_P'(4);
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset && !i_redirect_valid) begin
            r_mem_instr[r_wr_ptr] <= i_imem_rsp_data;
            r_mem_pc[r_wr_ptr]    <= r_rsp_pc;
        end
    end
endmodule
